sargantana_icache_ram_ctrl: RTL and testbench

- Access controller directly upstream of the icache set RAMs; one RAM instance per way, all sharing address, write-enable and write data.
- Arbitrates three sources onto the shared RAM port: invalidation sweeps (after reset and on flush), line refills from the memory interface, and tag/data lookups from the fetch stage.
- Returns lookup read data with a valid flag aligned to the RAMs' one-cycle read latency.

---
 rtl/sargantana_icache_ram_ctrl_if.sv | 39 +++
 rtl/sargantana_icache_ram_ctrl.sv | 111 +++++++++++
 tb/tb_sargantana_icache_ram_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sargantana_icache_ram_ctrl_if.sv
// Bundle of fetch-side, refill-side and RAM-side signals around the icache RAM controller.
// The controller takes the slave modport; the environment (fetch, refill, RAMs) takes master.
interface sargantana_icache_ram_ctrl_if #(
  parameter int N_WAYS = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
);
  logic                       flush_i;
  logic                       busy_o;
  logic                       lookup_valid_i;
  logic                       lookup_ready_o;
  logic [ADDR_W-1:0]          lookup_addr_i;
  logic                       refill_valid_i;
  logic                       refill_ready_o;
  logic [N_WAYS-1:0]          refill_way_i;
  logic [ADDR_W-1:0]          refill_addr_i;
  logic [DATA_W-1:0]          refill_data_i;
  logic [N_WAYS-1:0]          ram_req_o;
  logic                       ram_we_o;
  logic [ADDR_W-1:0]          ram_addr_o;
  logic [DATA_W-1:0]          ram_data_o;
  logic [N_WAYS*DATA_W-1:0]   ram_data_i;
  logic                       rd_valid_o;
  logic [N_WAYS*DATA_W-1:0]   rd_data_o;

  modport slave (
    input  flush_i, lookup_valid_i, lookup_addr_i, refill_valid_i,
           refill_way_i, refill_addr_i, refill_data_i, ram_data_i,
    output busy_o, lookup_ready_o, refill_ready_o, ram_req_o, ram_we_o,
           ram_addr_o, ram_data_o, rd_valid_o, rd_data_o
  );

  modport master (
    output flush_i, lookup_valid_i, lookup_addr_i, refill_valid_i,
           refill_way_i, refill_addr_i, refill_data_i, ram_data_i,
    input  busy_o, lookup_ready_o, refill_ready_o, ram_req_o, ram_we_o,
           ram_addr_o, ram_data_o, rd_valid_o, rd_data_o
  );
endinterface

// File: rtl/sargantana_icache_ram_ctrl.sv
// Icache set-RAM access controller: invalidation sweeps, refill writes and lookup reads
// arbitrated onto one shared RAM port, with a read-valid aligned to the 1-cycle RAM latency.
module sargantana_icache_ram_ctrl #(
  parameter int N_WAYS = 4,
  parameter int ADDR_W = 6,
  parameter int DATA_W = 128
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  sargantana_icache_ram_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_cnt;
  logic [ADDR_W-1:0]   w_cnt_nxt;
  logic                r_rd_valid;
  logic                w_lookup_hs;
  logic                w_busy;
  logic                w_lookup_ready;
  logic                w_refill_ready;
  logic [N_WAYS-1:0]   w_ram_req;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_ram_addr;
  logic [DATA_W-1:0]   w_ram_data;

  // State, sweep counter and read-valid registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= INIT;
      r_cnt      <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_rd_valid <= w_lookup_hs;
    end
  end

  // Next-state, arbitration and RAM port decode
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_busy         = 1'b0;
    w_lookup_ready = 1'b0;
    w_refill_ready = 1'b0;
    w_ram_req      = '0;
    w_ram_we       = 1'b0;
    w_ram_addr     = '0;
    w_ram_data     = '0;
    case (r_state)
      INIT, FLUSH: begin
        // Sweep writes zero to every set of every way; flush requests are ignored here
        w_busy     = 1'b1;
        w_ram_req  = '1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_cnt;
        if (r_cnt == {ADDR_W{1'b1}}) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + ADDR_W'(1);
        end
      end
      IDLE: begin
        if (bus.flush_i) begin
          w_state_nxt = FLUSH;
          w_cnt_nxt   = '0;
        end else begin
          w_refill_ready = 1'b1;
          w_lookup_ready = ~bus.refill_valid_i;
          if (bus.refill_valid_i) begin
            // Way select forwarded as-is, even if upstream breaks one-hotness
            w_ram_req  = bus.refill_way_i;
            w_ram_we   = 1'b1;
            w_ram_addr = bus.refill_addr_i;
            w_ram_data = bus.refill_data_i;
          end else if (bus.lookup_valid_i) begin
            w_ram_req  = '1;
            w_ram_addr = bus.lookup_addr_i;
          end else begin
            w_ram_req = '0;
          end
        end
      end
      default: begin
        w_state_nxt = INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_lookup_hs = bus.lookup_valid_i & w_lookup_ready;

  assign bus.busy_o         = w_busy;
  assign bus.lookup_ready_o = w_lookup_ready;
  assign bus.refill_ready_o = w_refill_ready;
  assign bus.ram_req_o      = w_ram_req;
  assign bus.ram_we_o       = w_ram_we;
  assign bus.ram_addr_o     = w_ram_addr;
  assign bus.ram_data_o     = w_ram_data;
  assign bus.rd_valid_o     = r_rd_valid;
  assign bus.rd_data_o      = bus.ram_data_i;

endmodule

// File: tb/tb_sargantana_icache_ram_ctrl.sv
// Bench for sargantana_icache_ram_ctrl: per-way RAM models plus a cache-content/sweep
// reference model; directed scenarios followed by a randomized traffic run.
module tb_sargantana_icache_ram_ctrl;
  localparam int N_WAYS = 4;
  localparam int ADDR_W = 6;
  localparam int DATA_W = 128;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sargantana_icache_ram_ctrl_if #(.N_WAYS(N_WAYS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_if ();

  sargantana_icache_ram_ctrl #(.N_WAYS(N_WAYS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_if)
  );

  // Set RAMs, one per way, one-cycle read latency
  logic [DATA_W-1:0] ram_mem [N_WAYS][DEPTH];
  logic [DATA_W-1:0] ram_q   [N_WAYS];
  always @(posedge clk) begin
    for (int w = 0; w < N_WAYS; w++) begin
      if (bus_if.ram_req_o[w]) begin
        if (bus_if.ram_we_o) ram_mem[w][bus_if.ram_addr_o] <= bus_if.ram_data_o;
        else                 ram_q[w] <= ram_mem[w][bus_if.ram_addr_o];
      end
    end
  end
  for (genvar g = 0; g < N_WAYS; g++) begin : g_rdata
    assign bus_if.ram_data_i[g*DATA_W +: DATA_W] = ram_q[g];
  end

  // Reference model: cache contents, sweep progress, pending response
  logic [DATA_W-1:0]        m_mem [N_WAYS][DEPTH];
  int                       m_sweep_left = 0;
  int                       m_sweep_idx  = 0;
  bit                       m_rv = 1'b0;
  logic [N_WAYS*DATA_W-1:0] m_rdata = '0;

  // Expected values for the current cycle
  bit                       e_busy, e_rv, e_full, e_lrdy, e_rrdy, e_we;
  logic [N_WAYS-1:0]        e_req;
  logic [ADDR_W-1:0]        e_addr;
  logic [DATA_W-1:0]        e_data;
  logic [N_WAYS*DATA_W-1:0] e_rdata;

  int n_cmp = 0;
  int n_err = 0;

  task automatic calc_expect();
    e_busy = (m_sweep_left > 0);
    e_rv = m_rv; e_rdata = m_rdata; e_full = 1'b1;
    e_lrdy = 1'b0; e_rrdy = 1'b0; e_req = '0; e_we = 1'b0; e_addr = '0; e_data = '0;
    if (e_busy) begin
      e_req = '1; e_we = 1'b1; e_addr = m_sweep_idx[ADDR_W-1:0];
    end else if (bus_if.flush_i) begin
      e_full = 1'b0;
    end else if (bus_if.refill_valid_i) begin
      e_rrdy = 1'b1; e_req = bus_if.refill_way_i; e_we = 1'b1;
      e_addr = bus_if.refill_addr_i; e_data = bus_if.refill_data_i;
    end else begin
      e_rrdy = 1'b1; e_lrdy = 1'b1;
      if (bus_if.lookup_valid_i) begin e_req = '1; e_addr = bus_if.lookup_addr_i; end
    end
  endtask

  // Advance the model by one clock using the inputs presented this cycle, then clock
  task automatic tick();
    bit nxt_rv = 1'b0;
    if (m_sweep_left > 0) begin
      for (int w = 0; w < N_WAYS; w++) m_mem[w][m_sweep_idx] = '0;
      m_sweep_idx++; m_sweep_left--;
      if (m_sweep_left == 0) m_sweep_idx = 0;
    end else if (bus_if.flush_i) begin
      m_sweep_left = DEPTH; m_sweep_idx = 0;
    end else if (bus_if.refill_valid_i) begin
      for (int w = 0; w < N_WAYS; w++)
        if (bus_if.refill_way_i[w]) m_mem[w][bus_if.refill_addr_i] = bus_if.refill_data_i;
    end else if (bus_if.lookup_valid_i) begin
      nxt_rv = 1'b1;
      for (int w = 0; w < N_WAYS; w++) m_rdata[w*DATA_W +: DATA_W] = m_mem[w][bus_if.lookup_addr_i];
    end
    if (rst) begin m_sweep_left = DEPTH; m_sweep_idx = 0; nxt_rv = 1'b0; end
    m_rv = nxt_rv;
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    bus_if.flush_i = 1'b0; bus_if.lookup_valid_i = 1'b0; bus_if.lookup_addr_i = '0;
    bus_if.refill_valid_i = 1'b0; bus_if.refill_way_i = '0; bus_if.refill_addr_i = '0;
    bus_if.refill_data_i = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear_inputs();
    @(negedge clk); tick();
    @(negedge clk); calc_expect();
    n_cmp++; if (bus_if.busy_o !== 1'b1) begin n_err++; $display("FAIL reset_busy got=%b exp=1", bus_if.busy_o); end
    n_cmp++; if (bus_if.ram_req_o !== 4'b1111) begin n_err++; $display("FAIL reset_req got=%b exp=1111", bus_if.ram_req_o); end
    n_cmp++; if (bus_if.rd_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rdv got=%b exp=0", bus_if.rd_valid_o); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk); calc_expect();
      n_cmp++;
      if (bus_if.busy_o !== 1'b1 || bus_if.ram_addr_o !== ADDR_W'(i) || bus_if.ram_we_o !== 1'b1 ||
          bus_if.ram_req_o !== 4'b1111 || bus_if.ram_data_o !== '0) begin
        n_err++;
        $display("FAIL init_sweep i=%0d busy=%b addr=%0d we=%b req=%b data=%h exp busy=1 addr=%0d we=1 req=1111 data=0",
                 i, bus_if.busy_o, bus_if.ram_addr_o, bus_if.ram_we_o, bus_if.ram_req_o, bus_if.ram_data_o, i);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus_if.busy_o !== 1'b0) begin n_err++; $display("FAIL init_end_busy got=%b exp=0", bus_if.busy_o); end
    tick();
  endtask

  task automatic test_refill_then_lookup();
    bus_if.refill_valid_i = 1'b1; bus_if.refill_way_i = 4'b0100; bus_if.refill_addr_i = 6'd5;
    bus_if.refill_data_i = 128'hA5; bus_if.lookup_valid_i = 1'b1; bus_if.lookup_addr_i = 6'd5;
    @(negedge clk);
    n_cmp++; if (bus_if.refill_ready_o !== 1'b1) begin n_err++; $display("FAIL rl_rrdy got=%b exp=1", bus_if.refill_ready_o); end
    n_cmp++; if (bus_if.lookup_ready_o !== 1'b0) begin n_err++; $display("FAIL rl_lrdy_blocked got=%b exp=0", bus_if.lookup_ready_o); end
    n_cmp++; if (bus_if.ram_req_o !== 4'b0100 || bus_if.ram_we_o !== 1'b1 || bus_if.ram_addr_o !== 6'd5)
      begin n_err++; $display("FAIL rl_ram req=%b we=%b addr=%0d exp req=0100 we=1 addr=5", bus_if.ram_req_o, bus_if.ram_we_o, bus_if.ram_addr_o); end
    tick();
    bus_if.refill_valid_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus_if.lookup_ready_o !== 1'b1) begin n_err++; $display("FAIL rl_lrdy got=%b exp=1", bus_if.lookup_ready_o); end
    tick();
    clear_inputs();
    @(negedge clk); calc_expect();
    n_cmp++; if (bus_if.rd_valid_o !== 1'b1) begin n_err++; $display("FAIL rl_rdv got=%b exp=1", bus_if.rd_valid_o); end
    n_cmp++; if (bus_if.rd_data_o[2*DATA_W +: DATA_W] !== 128'hA5)
      begin n_err++; $display("FAIL rl_way2 got=%h exp=a5", bus_if.rd_data_o[2*DATA_W +: DATA_W]); end
    n_cmp++; if (bus_if.rd_data_o !== e_rdata) begin n_err++; $display("FAIL rl_rdata got=%h exp=%h", bus_if.rd_data_o, e_rdata); end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int a = 1; a <= 3; a++) begin
      bus_if.refill_valid_i = 1'b1; bus_if.refill_way_i = 4'b0001 << $urandom_range(0, 3);
      bus_if.refill_addr_i = ADDR_W'(a); bus_if.refill_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      @(negedge clk); tick();
    end
    clear_inputs();
    for (int k = 0; k < 5; k++) begin
      bus_if.lookup_valid_i = (k < 3); bus_if.lookup_addr_i = ADDR_W'(k + 1);
      @(negedge clk); calc_expect();
      if (k < 3) begin
        n_cmp++; if (bus_if.lookup_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_lrdy k=%0d got=%b exp=1", k, bus_if.lookup_ready_o); end
      end
      n_cmp++; if (bus_if.rd_valid_o !== (k >= 1 && k <= 3)) begin n_err++; $display("FAIL b2b_rdv k=%0d got=%b exp=%b", k, bus_if.rd_valid_o, (k >= 1 && k <= 3)); end
      if (k >= 1 && k <= 3) begin
        n_cmp++; if (bus_if.rd_data_o !== e_rdata) begin n_err++; $display("FAIL b2b_rdata k=%0d got=%h exp=%h", k, bus_if.rd_data_o, e_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_flush();
    bus_if.lookup_valid_i = 1'b1; bus_if.lookup_addr_i = 6'd1;
    @(negedge clk); tick();
    bus_if.flush_i = 1'b1; bus_if.lookup_addr_i = 6'd5;
    @(negedge clk); calc_expect();
    n_cmp++; if (bus_if.rd_valid_o !== 1'b1) begin n_err++; $display("FAIL fl_keep_rdv got=%b exp=1", bus_if.rd_valid_o); end
    n_cmp++; if (bus_if.rd_data_o !== e_rdata) begin n_err++; $display("FAIL fl_keep_rdata got=%h exp=%h", bus_if.rd_data_o, e_rdata); end
    n_cmp++; if (bus_if.lookup_ready_o !== 1'b0) begin n_err++; $display("FAIL fl_lrdy got=%b exp=0", bus_if.lookup_ready_o); end
    n_cmp++; if (bus_if.ram_req_o !== 4'b0000) begin n_err++; $display("FAIL fl_req got=%b exp=0000", bus_if.ram_req_o); end
    tick();
    bus_if.flush_i = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus_if.busy_o !== 1'b1 || bus_if.lookup_ready_o !== 1'b0 || bus_if.ram_addr_o !== ADDR_W'(i)) begin
        n_err++;
        $display("FAIL fl_sweep i=%0d busy=%b lrdy=%b addr=%0d exp busy=1 lrdy=0 addr=%0d", i, bus_if.busy_o, bus_if.lookup_ready_o, bus_if.ram_addr_o, i);
      end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (bus_if.lookup_ready_o !== 1'b1 || bus_if.busy_o !== 1'b0)
      begin n_err++; $display("FAIL fl_after busy=%b lrdy=%b exp busy=0 lrdy=1", bus_if.busy_o, bus_if.lookup_ready_o); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_cmp++; if (bus_if.rd_valid_o !== 1'b1 || bus_if.rd_data_o !== '0)
      begin n_err++; $display("FAIL fl_zero rdv=%b data=%h exp rdv=1 data=0", bus_if.rd_valid_o, bus_if.rd_data_o); end
    tick();
  endtask

  task automatic test_flush_during_sweep();
    int busy_cnt = 0;
    for (int i = 0; i < 70; i++) begin
      bus_if.flush_i = (i == 0 || i == 11);
      @(negedge clk); calc_expect();
      if (bus_if.busy_o === 1'b1) busy_cnt++;
      n_cmp++; if (bus_if.busy_o !== e_busy || (e_busy && bus_if.ram_addr_o !== e_addr))
        begin n_err++; $display("FAIL fds_cycle i=%0d busy=%b addr=%0d exp busy=%b addr=%0d", i, bus_if.busy_o, bus_if.ram_addr_o, e_busy, e_addr); end
      tick();
    end
    clear_inputs();
    n_cmp++; if (busy_cnt != DEPTH) begin n_err++; $display("FAIL fds_len got=%0d exp=%0d", busy_cnt, DEPTH); end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cnt = 0;
    bus_if.lookup_valid_i = 1'b1; bus_if.lookup_addr_i = 6'd3; rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus_if.lookup_ready_o !== 1'b1) begin n_err++; $display("FAIL rms_lrdy got=%b exp=1", bus_if.lookup_ready_o); end
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      rst = (k == 30);
      @(negedge clk);
      n_cmp++; if (bus_if.rd_valid_o !== 1'b0 || bus_if.busy_o !== 1'b1 || bus_if.ram_addr_o !== ADDR_W'(k))
        begin n_err++; $display("FAIL rms_pre k=%0d rdv=%b busy=%b addr=%0d exp rdv=0 busy=1 addr=%0d", k, bus_if.rd_valid_o, bus_if.busy_o, bus_if.ram_addr_o, k); end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk); calc_expect();
      if (bus_if.busy_o === 1'b1) begin
        n_cmp++; if (bus_if.ram_addr_o !== ADDR_W'(busy_cnt) || bus_if.rd_valid_o !== 1'b0)
          begin n_err++; $display("FAIL rms_sweep i=%0d addr=%0d rdv=%b exp addr=%0d rdv=0", i, bus_if.ram_addr_o, bus_if.rd_valid_o, busy_cnt); end
        busy_cnt++;
      end
      tick();
    end
    clear_inputs();
    n_cmp++; if (busy_cnt != DEPTH) begin n_err++; $display("FAIL rms_len got=%0d exp=%0d", busy_cnt, DEPTH); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bus_if.flush_i = ($urandom_range(0, 99) < 2);
      bus_if.refill_valid_i = ($urandom_range(0, 99) < 35);
      bus_if.refill_way_i = ($urandom_range(0, 9) == 0) ? 4'($urandom()) : (4'b0001 << $urandom_range(0, 3));
      bus_if.refill_addr_i = ADDR_W'($urandom_range(0, 7));
      bus_if.refill_data_i = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus_if.lookup_valid_i = ($urandom_range(0, 99) < 60);
      bus_if.lookup_addr_i = ADDR_W'($urandom_range(0, 7));
      @(negedge clk); calc_expect();
      n_cmp++; if (bus_if.busy_o !== e_busy || bus_if.rd_valid_o !== e_rv || bus_if.ram_req_o !== e_req)
        begin n_err++; $display("FAIL rnd_ctl i=%0d busy=%b rdv=%b req=%b exp busy=%b rdv=%b req=%b", i, bus_if.busy_o, bus_if.rd_valid_o, bus_if.ram_req_o, e_busy, e_rv, e_req); end
      if (e_full) begin
        n_cmp++; if (bus_if.ram_we_o !== e_we || bus_if.ram_addr_o !== e_addr || bus_if.ram_data_o !== e_data)
          begin n_err++; $display("FAIL rnd_ram i=%0d we=%b addr=%0d data=%h exp we=%b addr=%0d data=%h", i, bus_if.ram_we_o, bus_if.ram_addr_o, bus_if.ram_data_o, e_we, e_addr, e_data); end
      end
      if (bus_if.refill_valid_i) begin
        n_cmp++; if (bus_if.refill_ready_o !== e_rrdy) begin n_err++; $display("FAIL rnd_rrdy i=%0d got=%b exp=%b", i, bus_if.refill_ready_o, e_rrdy); end
      end
      if (bus_if.lookup_valid_i) begin
        n_cmp++; if (bus_if.lookup_ready_o !== e_lrdy) begin n_err++; $display("FAIL rnd_lrdy i=%0d got=%b exp=%b", i, bus_if.lookup_ready_o, e_lrdy); end
      end
      if (e_rv) begin
        n_cmp++; if (bus_if.rd_data_o !== e_rdata) begin n_err++; $display("FAIL rnd_rdata i=%0d got=%h exp=%h", i, bus_if.rd_data_o, e_rdata); end
      end
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk); #1;
    test_reset();
    test_refill_then_lookup();
    test_back_to_back();
    test_flush();
    test_flush_during_sweep();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
